// File: rtl/acg_enable_controller.sv
// Per-group clock-enable controller: wake latency, ack handshake and idle hysteresis before gating.
// Optional gated-cycle statistics are compiled in when ACG_STATS_EN is defined.
module acg_enable_controller #(
    parameter int NUM_GROUPS = 2,
    parameter int WAKE_LAT   = 2,
    parameter int IDLE_HOLD  = 4
`ifdef ACG_STATS_EN
    ,
    parameter int STAT_W     = 16
`endif
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [NUM_GROUPS-1:0]        req,
    input  logic                         force_on,
`ifdef ACG_STATS_EN
    input  logic                         stat_clr,
    output logic [NUM_GROUPS*STAT_W-1:0] gated_cycles,
`endif
    output logic [NUM_GROUPS-1:0]        en,
    output logic [NUM_GROUPS-1:0]        ack,
    output logic [NUM_GROUPS-1:0]        gated
);

    typedef enum logic [1:0] {
        ST_GATED  = 2'd0,
        ST_WAKE   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // WAKE_LAT == 0 never enters WAKE, so its terminal count is irrelevant.
    localparam logic [3:0] WAKE_LAST = (WAKE_LAT > 0) ? 4'(WAKE_LAT - 1) : 4'd0;
    localparam logic [7:0] IDLE_LAST = 8'(IDLE_HOLD - 1);

    state_t                state_q [NUM_GROUPS];
    state_t                state_d [NUM_GROUPS];
    logic [3:0]            wake_q  [NUM_GROUPS];
    logic [3:0]            wake_d  [NUM_GROUPS];
    logic [7:0]            idle_q  [NUM_GROUPS];
    logic [7:0]            idle_d  [NUM_GROUPS];
    logic [NUM_GROUPS-1:0] en_q;
    logic [NUM_GROUPS-1:0] ack_q;
    logic [NUM_GROUPS-1:0] gated_q;

    always_comb begin
        for (int g = 0; g < NUM_GROUPS; g++) begin
            // NOTE: every next-state variable gets a default first so no path infers a latch.
            state_d[g] = state_q[g];
            wake_d[g]  = wake_q[g];
            idle_d[g]  = idle_q[g];
            case (state_q[g])
                ST_GATED: begin
                    if (req[g]) begin
                        wake_d[g]  = 4'd0;
                        state_d[g] = (WAKE_LAT == 0) ? ST_ACTIVE : ST_WAKE;
                    end
                end
                ST_WAKE: begin
                    // A dropped req does not abort the wake; ACTIVE then falls through to HOLD.
                    wake_d[g] = wake_q[g] + 4'd1;
                    if (wake_q[g] == WAKE_LAST) begin
                        state_d[g] = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (!req[g]) begin
                        idle_d[g]  = 8'd0;
                        state_d[g] = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    // Re-request beats expiry; force_on pins the idle count so gating restarts afresh.
                    if (req[g]) begin
                        state_d[g] = ST_ACTIVE;
                    end else if (force_on) begin
                        idle_d[g] = 8'd0;
                    end else if (idle_q[g] == IDLE_LAST) begin
                        state_d[g] = ST_GATED;
                    end else begin
                        idle_d[g] = idle_q[g] + 8'd1;
                    end
                end
                default: state_d[g] = ST_GATED;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int g = 0; g < NUM_GROUPS; g++) begin
                state_q[g] <= ST_GATED;
                wake_q[g]  <= 4'd0;
                idle_q[g]  <= 8'd0;
            end
            en_q    <= '0;
            ack_q   <= '0;
            gated_q <= '1;
        end else begin
            for (int g = 0; g < NUM_GROUPS; g++) begin
                // NOTE: non-blocking assignments keep every group's registers updating from pre-edge values.
                state_q[g] <= state_d[g];
                wake_q[g]  <= wake_d[g];
                idle_q[g]  <= idle_d[g];
                en_q[g]    <= (state_d[g] != ST_GATED);
                ack_q[g]   <= (state_d[g] == ST_ACTIVE) || (state_d[g] == ST_HOLD);
                gated_q[g] <= (state_d[g] == ST_GATED);
            end
        end
    end

    // force_on is itself registered upstream, so the OR stays glitch-free.
    assign en    = en_q | {NUM_GROUPS{force_on}};
    assign ack   = ack_q;
    assign gated = gated_q;

`ifdef ACG_STATS_EN
    logic [STAT_W-1:0] stat_q [NUM_GROUPS];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int g = 0; g < NUM_GROUPS; g++) begin
                stat_q[g] <= '0;
            end
        end else begin
            for (int g = 0; g < NUM_GROUPS; g++) begin
                if (stat_clr) begin
                    stat_q[g] <= '0;
                end else if (!en[g] && (stat_q[g] != '1)) begin
                    stat_q[g] <= stat_q[g] + STAT_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_stat_out
        assign gated_cycles[g*STAT_W +: STAT_W] = stat_q[g];
    end
`endif

endmodule

// File: tb/tb_acg_enable_controller.sv
// Directed scoreboard bench for acg_enable_controller (NUM_GROUPS=2, WAKE_LAT=2, IDLE_HOLD=4).
// Statistics checks are included when ACG_STATS_EN is defined.
module tb_acg_enable_controller;

    logic       CLK = 1'b0;
    logic       RST;
    logic [1:0] req;
    logic       force_on;
    logic [1:0] en;
    logic [1:0] ack;
    logic [1:0] gated;
`ifdef ACG_STATS_EN
    logic       stat_clr;
    logic [7:0] gated_cycles;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      tag;
        logic [1:0] en;
        logic [1:0] ack;
        logic [1:0] gated;
    } exp_t;

    exp_t sb [$];

    acg_enable_controller #(
        .NUM_GROUPS (2),
        .WAKE_LAT   (2),
        .IDLE_HOLD  (4)
`ifdef ACG_STATS_EN
        ,
        .STAT_W     (4)
`endif
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .req          (req),
        .force_on     (force_on),
`ifdef ACG_STATS_EN
        .stat_clr     (stat_clr),
        .gated_cycles (gated_cycles),
`endif
        .en           (en),
        .ack          (ack),
        .gated        (gated)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic compare_front();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({e.tag, ".en"},    {30'd0, en},    {30'd0, e.en});
            check({e.tag, ".ack"},   {30'd0, ack},   {30'd0, e.ack});
            check({e.tag, ".gated"}, {30'd0, gated}, {30'd0, e.gated});
        end
    endtask

    // Drive inputs, queue what must appear after the next edge, then compare 1 time unit past it.
    task automatic step(input logic [1:0] r, input logic f, input string tag,
                        input logic [1:0] e_en, input logic [1:0] e_ack, input logic [1:0] e_gated);
        req      = r;
        force_on = f;
        sb.push_back('{tag, e_en, e_ack, e_gated});
        @(posedge CLK);
        #1;
        compare_front();
    endtask

    task automatic expect_now(input string tag,
                              input logic [1:0] e_en, input logic [1:0] e_ack, input logic [1:0] e_gated);
        sb.push_back('{tag, e_en, e_ack, e_gated});
        compare_front();
    endtask

    initial begin
        RST      = 1'b1;
        req      = 2'b00;
        force_on = 1'b0;
`ifdef ACG_STATS_EN
        stat_clr = 1'b0;
`endif
        repeat (2) @(posedge CLK);
        #1;
        expect_now("por", 2'b00, 2'b00, 2'b11);
        RST = 1'b0;

        // Both groups wake together, then an asynchronous reset lands mid-cycle.
        step(2'b11, 1'b0, "both_wake0", 2'b11, 2'b00, 2'b00);
        step(2'b11, 1'b0, "both_wake1", 2'b11, 2'b00, 2'b00);
        step(2'b11, 1'b0, "both_active", 2'b11, 2'b11, 2'b00);
        #3 RST = 1'b1;
        #1 expect_now("rst_async", 2'b00, 2'b00, 2'b11);
        repeat (3) step(2'b11, 1'b0, "rst_held", 2'b00, 2'b00, 2'b11);
        req = 2'b00;
        #2 RST = 1'b0;

        repeat (8) step(2'b00, 1'b0, "idle", 2'b00, 2'b00, 2'b11);
`ifdef ACG_STATS_EN
        check("stat_idle8", {24'd0, gated_cycles}, {24'd0, 8'h88});
        stat_clr = 1'b1;
        step(2'b00, 1'b0, "stat_clr", 2'b00, 2'b00, 2'b11);
        check("stat_cleared", {24'd0, gated_cycles}, 32'd0);
        stat_clr = 1'b0;
        repeat (20) step(2'b00, 1'b0, "stat_sat_idle", 2'b00, 2'b00, 2'b11);
        check("stat_saturated", {24'd0, gated_cycles}, {24'd0, 8'hFF});
`endif

        // Wake latency on group 0 only.
        step(2'b01, 1'b0, "wl_en", 2'b01, 2'b00, 2'b10);
        step(2'b01, 1'b0, "wl_wait", 2'b01, 2'b00, 2'b10);
        step(2'b01, 1'b0, "wl_ack", 2'b01, 2'b01, 2'b10);

        // Hysteresis: four edges of hold after the drop, gated on the fifth.
        repeat (4) step(2'b00, 1'b0, "hy_hold", 2'b01, 2'b01, 2'b10);
        step(2'b00, 1'b0, "hy_gate", 2'b00, 2'b00, 2'b11);

        // Re-request in the cycle HOLD would expire.
        step(2'b01, 1'b0, "rr_wake0", 2'b01, 2'b00, 2'b10);
        step(2'b01, 1'b0, "rr_wake1", 2'b01, 2'b00, 2'b10);
        step(2'b01, 1'b0, "rr_active", 2'b01, 2'b01, 2'b10);
        repeat (4) step(2'b00, 1'b0, "rr_hold", 2'b01, 2'b01, 2'b10);
        step(2'b01, 1'b0, "rr_reqd", 2'b01, 2'b01, 2'b10);
        step(2'b01, 1'b0, "rr_active2", 2'b01, 2'b01, 2'b10);
        repeat (4) step(2'b00, 1'b0, "rr_fresh_hold", 2'b01, 2'b01, 2'b10);
        step(2'b00, 1'b0, "rr_gate", 2'b00, 2'b00, 2'b11);

        // req dropped during WAKE still completes to ACTIVE, then holds.
        step(2'b01, 1'b0, "wd_start", 2'b01, 2'b00, 2'b10);
        step(2'b00, 1'b0, "wd_wake", 2'b01, 2'b00, 2'b10);
        step(2'b00, 1'b0, "wd_active", 2'b01, 2'b01, 2'b10);
        repeat (4) step(2'b00, 1'b0, "wd_hold", 2'b01, 2'b01, 2'b10);
        step(2'b00, 1'b0, "wd_gate", 2'b00, 2'b00, 2'b11);

        // force_on while group 1 holds; group 0 stays GATED but its en is forced.
        step(2'b10, 1'b0, "f_wake0", 2'b10, 2'b00, 2'b01);
        step(2'b10, 1'b0, "f_wake1", 2'b10, 2'b00, 2'b01);
        step(2'b10, 1'b0, "f_active", 2'b10, 2'b10, 2'b01);
        step(2'b00, 1'b0, "f_hold", 2'b10, 2'b10, 2'b01);
        repeat (10) step(2'b00, 1'b1, "f_forced", 2'b11, 2'b10, 2'b01);
        repeat (3) step(2'b00, 1'b0, "f_release", 2'b10, 2'b10, 2'b01);
        step(2'b00, 1'b0, "f_gate", 2'b00, 2'b00, 2'b11);

        // Reset mid-HOLD drops ack asynchronously.
        step(2'b01, 1'b0, "h_wake0", 2'b01, 2'b00, 2'b10);
        step(2'b01, 1'b0, "h_wake1", 2'b01, 2'b00, 2'b10);
        step(2'b01, 1'b0, "h_active", 2'b01, 2'b01, 2'b10);
        step(2'b00, 1'b0, "h_hold", 2'b01, 2'b01, 2'b10);
        #2 RST = 1'b1;
        #1 expect_now("rst_in_hold", 2'b00, 2'b00, 2'b11);
        step(2'b00, 1'b0, "rst_hold_stay", 2'b00, 2'b00, 2'b11);
        #2 RST = 1'b0;
        step(2'b00, 1'b0, "post_rst", 2'b00, 2'b00, 2'b11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
